// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: ALU opcodes, EX control bundle and forwarding source tags.
package mips_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_NOR = 4'd5,
    ALU_SLT = 4'd6,
    ALU_SLL = 4'd7,
    ALU_SRL = 4'd8,
    ALU_SRA = 4'd9,
    ALU_LUI = 4'd10
  } alu_op_t;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

  typedef struct packed {
    alu_op_t alu_op;
    logic    use_imm;
    logic    use_shamt;
    logic    uses_rt;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
  } ex_ctrl_t;

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Bundle between decode/forwarding sources and the ID/EX operand stage.
interface id_ex_operand_stage_if #(
  parameter int DATA_WIDTH     = mips_pkg::DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = mips_pkg::REG_ADDR_WIDTH,
  parameter int CNT_WIDTH      = 32
);
  import mips_pkg::*;

  // Flow control: the stage accepts the ID instruction every cycle unless
  // stall_o=1, in which case ID must hold its instruction and present it again.
  logic                      id_valid;
  logic [REG_ADDR_WIDTH-1:0] id_rs_addr;
  logic [REG_ADDR_WIDTH-1:0] id_rt_addr;
  logic [REG_ADDR_WIDTH-1:0] id_rd_addr;
  logic [DATA_WIDTH-1:0]     id_rs_data;
  logic [DATA_WIDTH-1:0]     id_rt_data;
  logic [DATA_WIDTH-1:0]     id_imm;
  logic [4:0]                id_shamt;
  ex_ctrl_t                  id_ctrl;
  logic                      flush;
  logic                      exm_reg_write;
  logic [REG_ADDR_WIDTH-1:0] exm_rd_addr;
  logic [DATA_WIDTH-1:0]     exm_result;
  logic                      wb_reg_write;
  logic [REG_ADDR_WIDTH-1:0] wb_rd_addr;
  logic [DATA_WIDTH-1:0]     wb_data;
  logic                      stall_o;
  logic                      ex_valid;
  logic [DATA_WIDTH-1:0]     alu_a;
  logic [DATA_WIDTH-1:0]     alu_b;
  alu_op_t                   alu_op;
  logic [DATA_WIDTH-1:0]     ex_store_data;
  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr;
  logic                      ex_reg_write;
  logic                      ex_mem_read;
  logic                      ex_mem_write;
  logic [CNT_WIDTH-1:0]      stall_count;
  fwd_sel_t                  rs_fwd_sel;
  fwd_sel_t                  rt_fwd_sel;

  modport master (
    output id_valid, id_rs_addr, id_rt_addr, id_rd_addr, id_rs_data, id_rt_data,
           id_imm, id_shamt, id_ctrl, flush,
           exm_reg_write, exm_rd_addr, exm_result, wb_reg_write, wb_rd_addr, wb_data,
    input  stall_o, ex_valid, alu_a, alu_b, alu_op, ex_store_data, ex_rd_addr,
           ex_reg_write, ex_mem_read, ex_mem_write, stall_count, rs_fwd_sel, rt_fwd_sel
  );

  modport slave (
    input  id_valid, id_rs_addr, id_rt_addr, id_rd_addr, id_rs_data, id_rt_data,
           id_imm, id_shamt, id_ctrl, flush,
           exm_reg_write, exm_rd_addr, exm_result, wb_reg_write, wb_rd_addr, wb_data,
    output stall_o, ex_valid, alu_a, alu_b, alu_op, ex_store_data, ex_rd_addr,
           ex_reg_write, ex_mem_read, ex_mem_write, stall_count, rs_fwd_sel, rt_fwd_sel
  );

endinterface

// File: rtl/operand_fwd_mux.sv
// Selects one EX operand: EX/MEM result, then WB data, then the held register value.
module operand_fwd_mux #(
  parameter int DATA_WIDTH     = mips_pkg::DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = mips_pkg::REG_ADDR_WIDTH
) (
  input  logic [REG_ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0]     reg_value,
  input  logic                      exm_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] exm_rd_addr,
  input  logic [DATA_WIDTH-1:0]     exm_result,
  input  logic                      wb_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd_addr,
  input  logic [DATA_WIDTH-1:0]     wb_data,
  output logic [DATA_WIDTH-1:0]     value,
  output mips_pkg::fwd_sel_t        sel
);
  import mips_pkg::*;

  always_comb begin
    sel   = FWD_REG;
    value = reg_value;
    // r0 is hard-wired: never forwarded, always zero.
    if (addr == '0) begin
      value = '0;
    end else if (exm_reg_write && (exm_rd_addr == addr)) begin
      sel   = FWD_MEM;
      value = exm_result;
    end else if (wb_reg_write && (wb_rd_addr == addr)) begin
      sel   = FWD_WB;
      value = wb_data;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with ID-side WB bypass, EX-side operand forwarding and load-use stall.
module id_ex_operand_stage #(
  parameter int DATA_WIDTH     = mips_pkg::DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = mips_pkg::REG_ADDR_WIDTH,
  parameter int CNT_WIDTH      = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  id_ex_operand_stage_if.slave bus
);
  import mips_pkg::*;

  logic                      ex_valid_q;
  alu_op_t                   alu_op_q;
  logic                      use_imm_q;
  logic                      use_shamt_q;
  logic                      reg_write_q;
  logic                      mem_read_q;
  logic                      mem_write_q;
  logic [REG_ADDR_WIDTH-1:0] rs_addr_q;
  logic [REG_ADDR_WIDTH-1:0] rt_addr_q;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_q;
  logic [DATA_WIDTH-1:0]     rs_val_q;
  logic [DATA_WIDTH-1:0]     rt_val_q;
  logic [DATA_WIDTH-1:0]     imm_q;
  logic [4:0]                shamt_q;
  logic [CNT_WIDTH-1:0]      stall_cnt_q;

  logic                      hz;
  logic                      stall;
  logic [DATA_WIDTH-1:0]     rs_cap;
  logic [DATA_WIDTH-1:0]     rt_cap;
  logic [DATA_WIDTH-1:0]     rs_fwd;
  logic [DATA_WIDTH-1:0]     rt_fwd;

  always_comb begin
    hz = ex_valid_q && mem_read_q && (rd_addr_q != '0) && bus.id_valid &&
         ((rd_addr_q == bus.id_rs_addr) ||
          (bus.id_ctrl.uses_rt && (rd_addr_q == bus.id_rt_addr)));
    stall = hz && !bus.flush;
    // The regfile is not write-through, so a same-cycle WB write must be caught here.
    rs_cap = bus.id_rs_data;
    rt_cap = bus.id_rt_data;
    if (bus.wb_reg_write && (bus.wb_rd_addr != '0) && (bus.wb_rd_addr == bus.id_rs_addr))
      rs_cap = bus.wb_data;
    if (bus.wb_reg_write && (bus.wb_rd_addr != '0) && (bus.wb_rd_addr == bus.id_rt_addr))
      rt_cap = bus.wb_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      alu_op_q    <= ALU_ADD;
      use_imm_q   <= 1'b0;
      use_shamt_q <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      rs_addr_q   <= '0;
      rt_addr_q   <= '0;
      rd_addr_q   <= '0;
      rs_val_q    <= '0;
      rt_val_q    <= '0;
      imm_q       <= '0;
      shamt_q     <= '0;
    end else if (bus.flush || hz) begin
      // Bubble: kill the slot and its side effects, leave the datapath holding.
      ex_valid_q  <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      ex_valid_q  <= bus.id_valid;
      alu_op_q    <= bus.id_ctrl.alu_op;
      use_imm_q   <= bus.id_ctrl.use_imm;
      use_shamt_q <= bus.id_ctrl.use_shamt;
      reg_write_q <= bus.id_ctrl.reg_write;
      mem_read_q  <= bus.id_ctrl.mem_read;
      mem_write_q <= bus.id_ctrl.mem_write;
      rs_addr_q   <= bus.id_rs_addr;
      rt_addr_q   <= bus.id_rt_addr;
      rd_addr_q   <= bus.id_rd_addr;
      rs_val_q    <= rs_cap;
      rt_val_q    <= rt_cap;
      imm_q       <= bus.id_imm;
      shamt_q     <= bus.id_shamt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt_q <= '0;
    else if (stall && (stall_cnt_q != '1))
      stall_cnt_q <= stall_cnt_q + 1'b1;
  end

  operand_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_rs_fwd (
    .addr          (rs_addr_q),
    .reg_value     (rs_val_q),
    .exm_reg_write (bus.exm_reg_write),
    .exm_rd_addr   (bus.exm_rd_addr),
    .exm_result    (bus.exm_result),
    .wb_reg_write  (bus.wb_reg_write),
    .wb_rd_addr    (bus.wb_rd_addr),
    .wb_data       (bus.wb_data),
    .value         (rs_fwd),
    .sel           (bus.rs_fwd_sel)
  );

  operand_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_rt_fwd (
    .addr          (rt_addr_q),
    .reg_value     (rt_val_q),
    .exm_reg_write (bus.exm_reg_write),
    .exm_rd_addr   (bus.exm_rd_addr),
    .exm_result    (bus.exm_result),
    .wb_reg_write  (bus.wb_reg_write),
    .wb_rd_addr    (bus.wb_rd_addr),
    .wb_data       (bus.wb_data),
    .value         (rt_fwd),
    .sel           (bus.rt_fwd_sel)
  );

  assign bus.stall_o       = stall;
  assign bus.ex_valid      = ex_valid_q;
  assign bus.alu_a         = use_shamt_q ? {{(DATA_WIDTH-5){1'b0}}, shamt_q} : rs_fwd;
  assign bus.alu_b         = use_imm_q ? imm_q : rt_fwd;
  assign bus.alu_op        = alu_op_q;
  assign bus.ex_store_data = rt_fwd;
  assign bus.ex_rd_addr    = rd_addr_q;
  assign bus.ex_reg_write  = ex_valid_q && reg_write_q;
  assign bus.ex_mem_read   = ex_valid_q && mem_read_q;
  assign bus.ex_mem_write  = ex_valid_q && mem_write_q;
  assign bus.stall_count   = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed and random checks of the ID/EX operand stage against an instruction-level model.
module tb_id_ex_operand_stage;
  import mips_pkg::*;

  localparam int DW      = 32;
  localparam int RAW     = 5;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RAW), .CNT_WIDTH(CW)) bus ();

  id_ex_operand_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RAW), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // The instruction currently sitting in EX, as the model sees it.
  typedef struct {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic [4:0]  shamt;
    ex_ctrl_t    ctrl;
  } ex_model_t;

  ex_model_t m;
  int        m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m.valid  = 1'b0;
    m.rs     = '0;
    m.rt     = '0;
    m.rd     = '0;
    m.rs_val = '0;
    m.rt_val = '0;
    m.imm    = '0;
    m.shamt  = '0;
    m.ctrl   = '0;
    m_cnt    = 0;
  endtask

  // Register value seen by an instruction reading 'a' while holding 'held'.
  function automatic logic [31:0] ref_operand(input logic [4:0] a, input logic [31:0] held);
    if (a == 5'd0) return 32'd0;
    if (bus.exm_reg_write && bus.exm_rd_addr == a) return bus.exm_result;
    if (bus.wb_reg_write && bus.wb_rd_addr == a) return bus.wb_data;
    return held;
  endfunction

  function automatic fwd_sel_t ref_source(input logic [4:0] a);
    if (a == 5'd0) return FWD_REG;
    if (bus.exm_reg_write && bus.exm_rd_addr == a) return FWD_MEM;
    if (bus.wb_reg_write && bus.wb_rd_addr == a) return FWD_WB;
    return FWD_REG;
  endfunction

  function automatic logic [31:0] ref_capture(input logic [4:0] a, input logic [31:0] rf);
    if (bus.wb_reg_write && bus.wb_rd_addr != 5'd0 && bus.wb_rd_addr == a) return bus.wb_data;
    return rf;
  endfunction

  function automatic logic load_use();
    return m.valid && m.ctrl.mem_read && (m.rd != 5'd0) && bus.id_valid &&
           ((m.rd == bus.id_rs_addr) || (bus.id_ctrl.uses_rt && m.rd == bus.id_rt_addr));
  endfunction

  task automatic check_all();
    logic [31:0] a_exp;
    logic [31:0] b_exp;
    a_exp = m.ctrl.use_shamt ? {27'd0, m.shamt} : ref_operand(m.rs, m.rs_val);
    b_exp = m.ctrl.use_imm ? m.imm : ref_operand(m.rt, m.rt_val);
    chk("stall_o", 32'(bus.stall_o), 32'(load_use() && !bus.flush));
    chk("ex_valid", 32'(bus.ex_valid), 32'(m.valid));
    chk("alu_a", bus.alu_a, a_exp);
    chk("alu_b", bus.alu_b, b_exp);
    chk("alu_op", 32'(bus.alu_op), 32'(m.ctrl.alu_op));
    chk("store_data", bus.ex_store_data, ref_operand(m.rt, m.rt_val));
    chk("ex_rd_addr", 32'(bus.ex_rd_addr), 32'(m.rd));
    chk("ex_reg_write", 32'(bus.ex_reg_write), 32'(m.valid && m.ctrl.reg_write));
    chk("ex_mem_read", 32'(bus.ex_mem_read), 32'(m.valid && m.ctrl.mem_read));
    chk("ex_mem_write", 32'(bus.ex_mem_write), 32'(m.valid && m.ctrl.mem_write));
    chk("stall_count", 32'(bus.stall_count), 32'(m_cnt));
    chk("rs_fwd_sel", 32'(bus.rs_fwd_sel), 32'(ref_source(m.rs)));
    chk("rt_fwd_sel", 32'(bus.rt_fwd_sel), 32'(ref_source(m.rt)));
  endtask

  task automatic model_clock();
    logic h;
    h = load_use();
    if (h && !bus.flush && m_cnt < CNT_MAX) m_cnt++;
    if (bus.flush || h) begin
      m.valid = 1'b0;
    end else begin
      m.valid  = bus.id_valid;
      m.rs     = bus.id_rs_addr;
      m.rt     = bus.id_rt_addr;
      m.rd     = bus.id_rd_addr;
      m.rs_val = ref_capture(bus.id_rs_addr, bus.id_rs_data);
      m.rt_val = ref_capture(bus.id_rt_addr, bus.id_rt_data);
      m.imm    = bus.id_imm;
      m.shamt  = bus.id_shamt;
      m.ctrl   = bus.id_ctrl;
    end
  endtask

  // Starts and ends just after a falling edge; inputs must already be driven.
  task automatic tick();
    #1;
    check_all();
    model_clock();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic ex_ctrl_t mk_ctrl(input alu_op_t op, input logic ui, input logic us,
                                       input logic urt, input logic rw, input logic mr,
                                       input logic mw);
    ex_ctrl_t c;
    c.alu_op    = op;
    c.use_imm   = ui;
    c.use_shamt = us;
    c.uses_rt   = urt;
    c.reg_write = rw;
    c.mem_read  = mr;
    c.mem_write = mw;
    return c;
  endfunction

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                        input logic [31:0] imm, input logic [4:0] sh, input ex_ctrl_t c);
    bus.id_valid   = v;
    bus.id_rs_addr = rs;
    bus.id_rt_addr = rt;
    bus.id_rd_addr = rd;
    bus.id_rs_data = rsd;
    bus.id_rt_data = rtd;
    bus.id_imm     = imm;
    bus.id_shamt   = sh;
    bus.id_ctrl    = c;
  endtask

  task automatic set_fwd(input logic erw, input logic [4:0] erd, input logic [31:0] eres,
                         input logic wrw, input logic [4:0] wrd, input logic [31:0] wd);
    bus.exm_reg_write = erw;
    bus.exm_rd_addr   = erd;
    bus.exm_result    = eres;
    bus.wb_reg_write  = wrw;
    bus.wb_rd_addr    = wrd;
    bus.wb_data       = wd;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, '0);
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    bus.flush = 1'b0;
  endtask

  task automatic drive_random();
    ex_ctrl_t c;
    c.alu_op    = alu_op_t'(4'($urandom_range(0, 10)));
    c.use_imm   = 1'($urandom_range(0, 1));
    c.use_shamt = ($urandom_range(0, 3) == 0);
    c.uses_rt   = 1'($urandom_range(0, 1));
    c.reg_write = 1'($urandom_range(0, 1));
    c.mem_read  = ($urandom_range(0, 2) == 0);
    c.mem_write = ($urandom_range(0, 3) == 0);
    set_id(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), $urandom(), $urandom(), $urandom(),
           5'($urandom_range(0, 31)), c);
    set_fwd(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom(),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom());
    bus.flush = ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    ex_ctrl_t add_c;
    ex_ctrl_t lw_c;
    add_c = mk_ctrl(ALU_ADD, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    lw_c  = mk_ctrl(ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    idle();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("rst_alu_op", 32'(bus.alu_op), 32'(ALU_ADD));
    rst_n = 1'b1;
    @(negedge clk);

    // MEM beats WB for the same register.
    set_id(1'b1, 5'd3, 5'd4, 5'd8, 32'h1000, 32'h2000, 32'd0, 5'd0, add_c);
    tick();
    idle();
    set_fwd(1'b1, 5'd3, 32'h55, 1'b1, 5'd3, 32'h11);
    #1;
    chk("t2_alu_a", bus.alu_a, 32'h55);
    chk("t2_rs_sel", 32'(bus.rs_fwd_sel), 32'(FWD_MEM));
    tick();

    // r0 never forwards.
    idle();
    set_id(1'b1, 5'd0, 5'd0, 5'd9, 32'd0, 32'd0, 32'd0, 5'd0, add_c);
    tick();
    idle();
    set_fwd(1'b1, 5'd0, 32'hFF, 1'b1, 5'd0, 32'hEE);
    #1;
    chk("t3_alu_a", bus.alu_a, 32'd0);
    chk("t3_alu_b", bus.alu_b, 32'd0);
    tick();

    // Load-use: one stall cycle, one bubble, then MEM supplies the load data.
    idle();
    set_id(1'b1, 5'd1, 5'd0, 5'd5, 32'h100, 32'd0, 32'h4, 5'd0, lw_c);
    tick();
    set_id(1'b1, 5'd5, 5'd2, 5'd10, 32'hDEAD, 32'h7, 32'd0, 5'd0, add_c);
    #1;
    chk("t4_stall", 32'(bus.stall_o), 32'd1);
    tick();
    chk("t4_bubble_valid", 32'(bus.ex_valid), 32'd0);
    chk("t4_stall_released", 32'(bus.stall_o), 32'd0);
    chk("t4_stall_count", 32'(bus.stall_count), 32'd1);
    tick();
    idle();
    set_fwd(1'b1, 5'd5, 32'hCAFE0005, 1'b0, 5'd0, 32'd0);
    #1;
    chk("t4_dep_valid", 32'(bus.ex_valid), 32'd1);
    chk("t4_dep_alu_a", bus.alu_a, 32'hCAFE0005);
    tick();

    // Flush together with a hazard: bubble, no stall, counter unchanged.
    idle();
    set_id(1'b1, 5'd1, 5'd0, 5'd6, 32'h200, 32'd0, 32'h8, 5'd0, lw_c);
    tick();
    set_id(1'b1, 5'd6, 5'd6, 5'd12, 32'h1, 32'h2, 32'd0, 5'd0, add_c);
    bus.flush = 1'b1;
    #1;
    chk("t5_stall", 32'(bus.stall_o), 32'd0);
    tick();
    idle();
    #1;
    chk("t5_valid", 32'(bus.ex_valid), 32'd0);
    chk("t5_stall_count", 32'(bus.stall_count), 32'd1);
    tick();

    // WB write of r7 captured at ID instead of the stale regfile read.
    idle();
    set_id(1'b1, 5'd1, 5'd7, 5'd11, 32'h1, 32'h3C, 32'h999, 5'd0, add_c);
    set_fwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hA5);
    tick();
    idle();
    #1;
    chk("t6_alu_b", bus.alu_b, 32'hA5);
    chk("t6_store_data", bus.ex_store_data, 32'hA5);
    tick();

    // Random traffic with an asynchronous reset dropped in mid-stream.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        drive_random();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t1_ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("t1_reg_write", 32'(bus.ex_reg_write), 32'd0);
        chk("t1_mem_read", 32'(bus.ex_mem_read), 32'd0);
        chk("t1_mem_write", 32'(bus.ex_mem_write), 32'd0);
        chk("t1_alu_op", 32'(bus.alu_op), 32'(ALU_ADD));
        chk("t1_stall_count", 32'(bus.stall_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
      end
      drive_random();
      tick();
    end

    // Drive far more stalls than the counter can hold.
    for (int i = 0; i < CNT_MAX + 5; i++) begin
      idle();
      set_id(1'b1, 5'd2, 5'd0, 5'd5, 32'h10, 32'd0, 32'h4, 5'd0, lw_c);
      tick();
      set_id(1'b1, 5'd3, 5'd5, 5'd9, 32'h1, 32'h2, 32'd0, 5'd0, add_c);
      tick();
      tick();
    end
    idle();
    #1;
    chk("sat_stall_count", 32'(bus.stall_count), 32'(CNT_MAX));
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
